// File: rtl/seq_signed_divider.sv
// seq_signed_divider: multi-cycle signed restoring divider, one quotient bit per clock
module seq_signed_divider #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic                  overflow
);
  localparam int CW = $clog2(DIVIDEND_W);
  localparam logic [CW-1:0] LAST = CW'(DIVIDEND_W - 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_nx;
  logic [DIVIDEND_W-1:0] dvd;
  logic [DIVISOR_W-1:0]  dvs;
  logic [DIVISOR_W:0]    pr, pr_sh;
  logic [CW-1:0]         cnt;
  logic                  sign_q, sign_r, ge, dz, ov;
  logic [DIVIDEND_W-1:0] q_fix;
  logic [DIVISOR_W-1:0]  r_fix;
  assign busy = state != IDLE;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state: accept in IDLE, iterate DIVIDEND_W times, one sign-fix cycle
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (start ? CALC : IDLE) :
               state == CALC ? (cnt == LAST ? FIX : CALC) : IDLE;
  end
  // trial subtraction and sign/flag resolution; with a zero divisor every trial
  // succeeds, so pr ends holding the low dividend magnitude bits and the signed
  // remainder path reproduces dividend[DIVISOR_W-1:0]
  always_comb begin
    pr_sh = (DIVISOR_W+1)'({pr, dvd[DIVIDEND_W-1]});
    ge    = pr_sh >= {1'b0, dvs};
    dz    = dvs == '0;
    ov    = sign_r && !sign_q && dvs == DIVISOR_W'(1) &&
            dvd == {1'b1, {(DIVIDEND_W-1){1'b0}}};
    q_fix = dz ? {sign_r, {(DIVIDEND_W-1){!sign_r}}} : (sign_q ? -dvd : dvd);
    r_fix = sign_r ? -pr[DIVISOR_W-1:0] : pr[DIVISOR_W-1:0];
  end
  // datapath: capture magnitudes, shift quotient bits into dvd, register results
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dvd         <= '0;
      dvs         <= '0;
      pr          <= '0;
      cnt         <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= state == FIX;
      if (state == IDLE && start) begin
        dvd    <= dividend[DIVIDEND_W-1] ? -dividend : dividend;
        dvs    <= divisor[DIVISOR_W-1] ? -divisor : divisor;
        sign_q <= dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
        sign_r <= dividend[DIVIDEND_W-1];
        pr     <= '0;
        cnt    <= '0;
      end else if (state == CALC) begin
        pr  <= ge ? pr_sh - {1'b0, dvs} : pr_sh;
        dvd <= {dvd[DIVIDEND_W-2:0], ge};
        cnt <= cnt + 1'b1;
      end else if (state == FIX) begin
        quotient    <= q_fix;
        remainder   <= r_fix;
        div_by_zero <= dz;
        overflow    <= ov;
      end
    end
endmodule

// File: tb/tb_seq_signed_divider.sv
// tb_seq_signed_divider: directed and randomized checks of the sequential signed divider
module tb_seq_signed_divider;
  logic        clk = 0, rst_n = 0, start = 0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        busy, done, div_by_zero, overflow;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  seq_signed_divider dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  // called at a negedge; returns at the negedge following the accepting edge
  task automatic go(input logic [15:0] a, input logic [7:0] b);
    dividend = a;
    divisor  = b;
    start    = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
  endtask

  // counts rising edges until done is seen (bounded)
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero, overflow} !== 28'h0) begin
      failures++;
      $display("FAIL reset_state got=%h want=0", {busy, done, quotient, remainder, div_by_zero, overflow});
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int n;
    go(16'd15, 8'd5);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b want=1", busy); end
    wait_done(n);
    checks++;
    if (n !== 17) begin failures++; $display("FAIL basic_latency got=%0d want=17", n); end
    checks++;
    if ({busy, quotient, remainder, div_by_zero, overflow} !== {1'b0, 16'd3, 8'd0, 2'b00}) begin
      failures++;
      $display("FAIL basic_15_5 got busy=%b q=%h r=%h dz=%b ov=%b want busy=0 q=0003 r=00 dz=0 ov=0",
               busy, quotient, remainder, div_by_zero, overflow);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL done_pulse got=%b want=0", done); end
  endtask

  task automatic test_back_to_back;
    int n;
    go(16'hFFF7, 8'd3);
    wait_done(n);
    checks++;
    if ({quotient, remainder, div_by_zero, overflow} !== {16'hFFFD, 8'h00, 2'b00}) begin
      failures++;
      $display("FAIL b2b_first got q=%h r=%h dz=%b ov=%b want q=fffd r=00", quotient, remainder, div_by_zero, overflow);
    end
    go(16'hFFC0, 8'hF8);
    wait_done(n);
    checks++;
    if (n !== 17) begin failures++; $display("FAIL b2b_latency got=%0d want=17", n); end
    checks++;
    if ({quotient, remainder, div_by_zero, overflow} !== {16'h0008, 8'h00, 2'b00}) begin
      failures++;
      $display("FAIL b2b_second got q=%h r=%h dz=%b ov=%b want q=0008 r=00", quotient, remainder, div_by_zero, overflow);
    end
  endtask

  task automatic test_signs;
    int n;
    go(16'hFFF9, 8'd2);
    wait_done(n);
    checks++;
    if ({quotient, remainder, div_by_zero, overflow} !== {16'hFFFD, 8'hFF, 2'b00}) begin
      failures++;
      $display("FAIL neg7_div_2 got q=%h r=%h dz=%b ov=%b want q=fffd r=ff", quotient, remainder, div_by_zero, overflow);
    end
    go(16'd7, 8'hFE);
    wait_done(n);
    checks++;
    if ({quotient, remainder, div_by_zero, overflow} !== {16'hFFFD, 8'h01, 2'b00}) begin
      failures++;
      $display("FAIL 7_div_neg2 got q=%h r=%h dz=%b ov=%b want q=fffd r=01", quotient, remainder, div_by_zero, overflow);
    end
  endtask

  task automatic test_overflow;
    int n;
    go(16'h8000, 8'hFF);
    wait_done(n);
    checks++;
    if (n !== 17) begin failures++; $display("FAIL ovf_latency got=%0d want=17", n); end
    checks++;
    if ({quotient, remainder, div_by_zero, overflow} !== {16'h8000, 8'h00, 2'b01}) begin
      failures++;
      $display("FAIL ovf_min_div_neg1 got q=%h r=%h dz=%b ov=%b want q=8000 r=00 ov=1", quotient, remainder, div_by_zero, overflow);
    end
    go(16'h8000, 8'h80);
    wait_done(n);
    checks++;
    if ({quotient, remainder, div_by_zero, overflow} !== {16'h0100, 8'h00, 2'b00}) begin
      failures++;
      $display("FAIL min_div_min got q=%h r=%h dz=%b ov=%b want q=0100 r=00", quotient, remainder, div_by_zero, overflow);
    end
  endtask

  task automatic test_div_zero;
    int n, extra;
    go(16'd254, 8'd0);
    repeat (3) @(negedge clk);
    dividend = 16'd1;
    divisor  = 8'd1;
    start    = 1;
    @(negedge clk);
    start = 0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL dz_busy got=%b want=1", busy); end
    wait_done(n);
    checks++;
    if (n !== 13) begin failures++; $display("FAIL dz_latency got=%0d want=13", n); end
    checks++;
    if ({quotient, remainder, div_by_zero, overflow} !== {16'h7FFF, 8'hFE, 2'b10}) begin
      failures++;
      $display("FAIL dz_254 got q=%h r=%h dz=%b ov=%b want q=7fff r=fe dz=1", quotient, remainder, div_by_zero, overflow);
    end
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) extra++;
    end
    checks++;
    if (extra !== 0) begin failures++; $display("FAIL ignored_start got=%0d dones want=0", extra); end
    go(16'hFFFB, 8'd0);
    wait_done(n);
    checks++;
    if ({quotient, remainder, div_by_zero, overflow} !== {16'h8000, 8'hFB, 2'b10}) begin
      failures++;
      $display("FAIL dz_neg5 got q=%h r=%h dz=%b ov=%b want q=8000 r=fb dz=1", quotient, remainder, div_by_zero, overflow);
    end
  endtask

  task automatic test_reset_abort;
    int n, extra;
    go(16'h3F01, 8'd127);
    repeat (6) @(negedge clk);
    #2 rst_n = 0;
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero, overflow} !== 28'h0) begin
      failures++;
      $display("FAIL abort_clear got=%h want=0", {busy, done, quotient, remainder, div_by_zero, overflow});
    end
    @(negedge clk);
    rst_n = 1;
    extra = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) extra++;
    end
    checks++;
    if (extra !== 0) begin failures++; $display("FAIL abort_no_done got=%0d dones want=0", extra); end
    go(16'h3F01, 8'h81);
    wait_done(n);
    checks++;
    if ({quotient, remainder, div_by_zero, overflow} !== {16'hFF81, 8'h00, 2'b00}) begin
      failures++;
      $display("FAIL 16129_div_neg127 got q=%h r=%h dz=%b ov=%b want q=ff81 r=00", quotient, remainder, div_by_zero, overflow);
    end
  endtask

  task automatic test_random;
    int n, a, b, q, r;
    logic [15:0] av;
    logic [7:0]  bv;
    for (int i = 0; i < 24; i++) begin
      av = 16'($urandom);
      bv = 8'($urandom);
      if (bv == 8'h00) bv = 8'h01;
      if (av == 16'h8000 && bv == 8'hFF) bv = 8'h03;
      a = $signed(av);
      b = $signed(bv);
      q = a / b;
      r = a % b;
      go(av, bv);
      wait_done(n);
      checks++;
      if ({quotient, remainder, div_by_zero, overflow} !== {q[15:0], r[7:0], 2'b00}) begin
        failures++;
        $display("FAIL rand_%0d %0d/%0d got q=%h r=%h dz=%b ov=%b want q=%h r=%h",
                 i, a, b, quotient, remainder, div_by_zero, overflow, q[15:0], r[7:0]);
      end
      checks++;
      if ($signed(quotient) * b + $signed(remainder) !== a) begin
        failures++;
        $display("FAIL rand_inv_%0d got=%0d want=%0d", i, $signed(quotient) * b + $signed(remainder), a);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_basic;
    test_back_to_back;
    test_signs;
    test_overflow;
    test_div_zero;
    test_reset_abort;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_signed_divider.md
Name: seq_signed_divider

Overview:
- Multi-cycle signed restoring divider: DIVIDEND_W-bit by DIVISOR_W-bit, one quotient bit per clock.
- Inverse datapath of the 8x8 Wallace multiplier: divides its 16-bit signed product back by an 8-bit operand.
- Used for MAC result scaling/normalisation and as a self-check against the multiplier.
- Start/done handshake; results held until the next completion.

Parameters:
- DIVIDEND_W, 16, dividend and quotient width (two's complement).
- DIVISOR_W, 8, divisor and remainder width (two's complement).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- dividend  input  DIVIDEND_W  signed dividend; captured on accepted start.
- divisor  input  DIVISOR_W  signed divisor; captured on accepted start.
- busy  output  1  high while a division is in progress.
- done  output  1  single-cycle pulse; results valid.
- quotient  output  DIVIDEND_W  signed quotient, truncated toward zero.
- remainder  output  DIVISOR_W  signed remainder; sign follows dividend.
- div_by_zero  output  1  result flag, updated with done.
- overflow  output  1  result flag, updated with done.

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low (rst_n).
  - rst_n low clears all outputs and internal registers to 0 and forces state IDLE.
  - Reset mid-operation aborts the division; no done is issued.
- States: IDLE, CALC, FIX.
- IDLE:
  - On start=1, capture |dividend|, |divisor|, sign_q = dividend[MSB]^divisor[MSB], sign_r = dividend[MSB].
  - Load counter = 0 and go to CALC; busy=1 from the next cycle.
- CALC:
  - Each cycle: shift the partial remainder (DIVISOR_W+1 bits, unsigned) left, bringing in the next dividend magnitude bit from the MSB.
  - Trial subtract |divisor|. If non-negative, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
  - After DIVIDEND_W iterations (counter = DIVIDEND_W-1), go to FIX.
- FIX (one cycle):
  - Apply signs: quotient = sign_q ? -q_mag : q_mag; remainder = sign_r ? -r_mag : r_mag.
  - Register quotient, remainder, div_by_zero and overflow; assert done=1; deassert busy; go to IDLE.
- Latency:
  - done is high in the cycle following the DIVIDEND_W+1-th rising edge after the accepting edge (17 for defaults).
  - Fixed for all operands, including the special cases below.
- Handshake:
  - start is ignored while busy=1.
  - start asserted in the same cycle done=1 is accepted (state is IDLE); back-to-back throughput is one result per DIVIDEND_W+1 cycles.
  - Outputs hold their last values until the next done; done is never high for two consecutive cycles.
- Magnitude arithmetic:
  - |most-negative| is handled by using DIVIDEND_W-bit / DIVISOR_W-bit unsigned magnitudes. For example, |-32768| = 0x8000 and |-128| = 0x80 are both legal.
- Divide by zero (divisor = 0):
  - quotient = dividend[MSB] ? {1'b1,0...} (most negative) : {1'b0,1...} (most positive).
  - remainder = dividend[DIVISOR_W-1:0]; div_by_zero=1; overflow=0.
- Overflow (dividend = most negative, divisor = -1):
  - quotient = most negative (0x8000), remainder = 0, overflow=1.
- In all other cases both flags are 0.
- Remainder magnitude is always < |divisor| ≤ 128, so it fits DIVISOR_W signed without saturation.
- Invariant (no flags set): quotient*divisor + remainder == dividend, with |remainder| < |divisor|.

Test Plan:
- Reset, then dividend=15, divisor=5 -> done after 17 edges; quotient=3, remainder=0, flags=0, busy low with done.
- dividend=-9 (0xFFF7), divisor=3; then dividend=-64, divisor=-8 -> quotient=0xFFFD/rem=0, then quotient=8/rem=0. The second start is issued in the first job's done cycle and must complete 17 edges later.
- dividend=-7, divisor=2 -> quotient=-3 (0xFFFD), remainder=-1 (0xFF); dividend=7, divisor=-2 -> quotient=-3, remainder=1.
- dividend=-32768, divisor=-1 -> quotient=0x8000, remainder=0, overflow=1. Then dividend=-32768, divisor=-128 -> quotient=256, remainder=0, overflow=0.
- dividend=254, divisor=0 -> quotient=0x7FFF, remainder=0xFE, div_by_zero=1. Pulse start while busy -> ignored, no extra done.
- Start 127*127=16129 / 127, pull rst_n low at cycle 8 -> all outputs 0 immediately, no done. Then run 16129/-127 -> quotient=-127, remainder=0. Finish with a random-operand sweep checking the invariant against a signed reference model.
